color_correction_matrix: RTL and testbench
==========================================

Name: color_correction_matrix

Overview:
- Pipelined 3x3 colour-correction matrix (CCM) stage, directly upstream of gamma correction.
- Converts 8-bit RGB pixels into scaled fixed-point channels (pixel << SCALE_BIT domain).
- Each output channel is consumed per channel by the gamma stage, which shifts right by SCALE_BIT and applies its LUT.
- Coefficients are runtime-programmable through double-buffered registers that swap only at frame start.

Parameters:
SIZE_INT, 32, width of each output channel word (matches the gamma stage's input width)
SCALE_BIT, 8, fractional bits of coefficients and of the output scale
COEF_W, 16, signed coefficient width (two's complement, SCALE_BIT fractional bits)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  input beat valid
in_ready  out  1  stage can accept input beat
in_sof  in  1  first pixel of frame, qualified by in_valid
in_r / in_g / in_b  in  8 each  unsigned input pixel channels
out_valid  out  1  output beat valid
out_ready  in  1  downstream accepts output beat
out_sof  out  1  sof travelling with the beat
out_r / out_g / out_b  out  SIZE_INT each  corrected channels, range 0..(256<<SCALE_BIT)-1, zero-extended
cfg_we  in  1  shadow coefficient write strobe
cfg_addr  in  4  coefficient index 0..8 (row-major: 0..2 = R row, 3..5 = G row, 6..8 = B row); 9..15 ignored
cfg_data  in  COEF_W  signed coefficient
cfg_commit  in  1  arm swap of shadow into active at next accepted sof beat
cfg_pending  out  1  swap armed, not yet taken

Behaviour:
- Reset (async assert, sync deassert by the system): all valid flags 0, out_* 0, out_sof 0, cfg_pending 0.
- Reset values of shadow and active: identity matrix (diagonal = 1<<SCALE_BIT, rest 0).
- Pipeline: 3 register stages.
  - S1: nine signed products, each channel zero-extended to signed 9 bits x COEF_W.
  - S2: three row sums, width COEF_W+11.
  - S3: clamp.
- Latency: exactly 3 cycles from accepted input to out_valid when unstalled.
- Clamp rules: sum < 0 -> 0; sum > (256<<SCALE_BIT)-1 -> (256<<SCALE_BIT)-1; otherwise the sum unchanged. No rounding: the result is already in the output scale.
- Handshake: advance = !out_valid || out_ready; in_ready = advance.
  - All stages shift only on advance; bubbles are carried as valid=0.
  - While !advance, every stage register holds and outputs are stable.
  - Beat order is preserved; no beat is dropped or duplicated.
- out_sof: pipelined alongside data; asserted only together with out_valid.
- Config write: cfg_we writes cfg_data into shadow[cfg_addr] the same cycle. Writes to addr > 8 have no effect. Active coefficients are unaffected.
- Commit:
  - A cfg_commit pulse sets cfg_pending.
  - On the cycle a beat with in_sof is accepted (in_valid && in_ready && in_sof) while pending: active <= shadow and pending clears. That beat and all later beats use the new coefficients.
  - cfg_commit in the same cycle as that swap: swap happens and pending stays set for the next frame.
  - cfg_we in the same cycle as the swap: the swap copies the old shadow value; the new write lands in shadow only.
- Reset mid-frame: pipeline is flushed and active/shadow return to identity; a cleared pending means a lost commit.

Optional Feature:
- Macro: CCM_SAT_COUNT_EN.
- Defined:
  - Adds output port sat_count (16 bits) holding the number of output beats, counted on out_valid && out_ready, in which any channel was clamped at either bound.
  - The counter saturates at 65535 and clears to 0 on rst_n or on a swap event.
- Undefined: the port and the counter are absent; other behaviour is identical.

Decomposition:
- Shared package/include holds SIZE_INT, SCALE_BIT, COEF_W defaults, the identity coefficient value, coefficient index constants, and the clamp maximum (256<<SCALE_BIT)-1.
- One natural sub-module, ccm_row: three multiplies, sum and clamp for one output channel, pipelined with the shared advance enable. It is instantiated three times.

Test Plan:
- Reset identity: in (10,2,255) -> after 3 cycles out (2560,512,65280), out_sof follows in_sof.
- Negative clamp: R row = (-256,0,0), commit, sof beat in_r=100 -> out_r=0, sat_count=1 when CCM_SAT_COUNT_EN is defined.
- Positive clamp: R row = (512,0,0), in_r=200 -> out_r=65535; with in_r=100 -> out_r=51200.
- Backpressure: stream 8 beats, drop out_ready for 5 cycles mid-stream -> in_ready low, outputs stable, all 8 beats in order, none lost.
- Commit timing: write coefficient 0 = 128, pulse commit, send non-sof in_r=100 -> out 25600 (old matrix); next sof beat in_r=100 -> out 12800, cfg_pending falls on that accept.
- Async reset with 3 beats in flight -> out_valid=0 immediately, no stale beats after release, identity coefficients restored.

Source files
------------

// File: rtl/color_correction_matrix_pkg.sv
// Shared widths, clamp bound, coefficient types and identity matrix for the CCM stage.
// Coefficients are signed with SCALE_BIT fractional bits; outputs stay in the pixel<<SCALE_BIT domain.
package color_correction_matrix_pkg;
  localparam int SIZE_INT  = 32;
  localparam int SCALE_BIT = 8;
  localparam int COEF_W    = 16;
  localparam int PIX_W     = 8;
  localparam int PROD_W    = COEF_W + PIX_W + 1;
  localparam int SUM_W     = COEF_W + 11;
  localparam int CLAMP_W   = SCALE_BIT + PIX_W;
  localparam int CLAMP_MAX = (256 << SCALE_BIT) - 1;
  localparam int NUM_COEF  = 9;
  localparam int ROW_LEN   = 3;
  localparam int IDX_R_ROW = 0;
  localparam int IDX_G_ROW = 3;
  localparam int IDX_B_ROW = 6;
  localparam logic [3:0] CFG_ADDR_MAX = 4'd8;

  typedef logic signed [COEF_W-1:0] coef_t;
  typedef coef_t [ROW_LEN-1:0]      coef_row_t;
  typedef coef_t [NUM_COEF-1:0]     coef_mat_t;
  typedef logic signed [PROD_W-1:0] prod_t;
  typedef logic signed [SUM_W-1:0]  sum_t;

  typedef struct packed {
    logic [PIX_W-1:0] r;
    logic [PIX_W-1:0] g;
    logic [PIX_W-1:0] b;
  } rgb8_t;

  localparam coef_t COEF_ONE = coef_t'(1 << SCALE_BIT);

  function automatic coef_mat_t identity_mat();
    coef_mat_t m;
    m = '0;
    for (int i = 0; i < ROW_LEN; i++) m[i*(ROW_LEN+1)] = COEF_ONE;
    return m;
  endfunction

  localparam coef_mat_t IDENTITY_MAT = identity_mat();
endpackage

// File: rtl/color_correction_matrix_ccm_row.sv
// One CCM output channel: multiply, row sum, clamp; 3 register stages, all gated by adv (holds when low).
// Optional clamp flag (CCM_SAT_COUNT_EN) travels with the clamped result.
module ccm_row
  import color_correction_matrix_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                adv,
  input  rgb8_t               px_dat,
  input  coef_row_t           coef_dat,
  output logic [SIZE_INT-1:0] out_dat
`ifdef CCM_SAT_COUNT_EN
  , output logic              out_clamp
`endif
);
  localparam sum_t SUM_MAX = sum_t'(CLAMP_MAX);

  prod_t [2:0]         prod_d, prod_q;
  sum_t                sum_d, sum_q;
  logic [SIZE_INT-1:0] out_d, out_q;
  logic                clamp_d, clamp_q;

  // Pixel is unsigned: widen with a zero sign bit before the signed multiply.
  function automatic prod_t mul(input logic [PIX_W-1:0] px, input coef_t c);
    return prod_t'($signed({1'b0, px})) * prod_t'(c);
  endfunction

  always_comb begin
    prod_d[0] = mul(px_dat.r, coef_dat[0]);
    prod_d[1] = mul(px_dat.g, coef_dat[1]);
    prod_d[2] = mul(px_dat.b, coef_dat[2]);
    sum_d     = sum_t'(prod_q[0]) + sum_t'(prod_q[1]) + sum_t'(prod_q[2]);
    out_d     = SIZE_INT'(sum_q[CLAMP_W-1:0]);
    clamp_d   = 1'b0;
    if (sum_q[SUM_W-1]) begin
      out_d   = '0;
      clamp_d = 1'b1;
    end else if (sum_q > SUM_MAX) begin
      out_d   = SIZE_INT'(CLAMP_MAX);
      clamp_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod_q  <= '0;
      sum_q   <= '0;
      out_q   <= '0;
      clamp_q <= 1'b0;
    end else if (adv) begin
      prod_q  <= prod_d;
      sum_q   <= sum_d;
      out_q   <= out_d;
      clamp_q <= clamp_d;
    end
  end

  assign out_dat = out_q;
`ifdef CCM_SAT_COUNT_EN
  assign out_clamp = clamp_q;
`else
  // Clamp flag only feeds the optional counter.
  logic unused_clamp;
  assign unused_clamp = clamp_q;
`endif
endmodule

// File: rtl/color_correction_matrix.sv
// 3x3 colour-correction matrix, 3-cycle latency; whole pipeline stalls when out_valid && !out_ready.
// Double-buffered coefficients swap on an accepted sof beat; CCM_SAT_COUNT_EN adds sat_count.
module color_correction_matrix
  import color_correction_matrix_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                in_sof,
  input  logic [PIX_W-1:0]    in_r,
  input  logic [PIX_W-1:0]    in_g,
  input  logic [PIX_W-1:0]    in_b,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                out_sof,
  output logic [SIZE_INT-1:0] out_r,
  output logic [SIZE_INT-1:0] out_g,
  output logic [SIZE_INT-1:0] out_b,
  input  logic                cfg_we,
  input  logic [3:0]          cfg_addr,
  input  logic [COEF_W-1:0]   cfg_data,
  input  logic                cfg_commit,
  output logic                cfg_pending
`ifdef CCM_SAT_COUNT_EN
  , output logic [15:0]       sat_count
`endif
);
  logic                adv, accept, swap;
  logic [2:0]          vld_d, vld_q, sof_d, sof_q;
  coef_mat_t           shadow_d, shadow_q, active_d, active_q, coef_use;
  logic                pend_d, pend_q;
  rgb8_t               px;
  logic [SIZE_INT-1:0] row_out [ROW_LEN];
  logic [ROW_LEN-1:0]  row_clamp;

  always_comb begin
    adv    = !vld_q[2] || out_ready;
    accept = in_valid && adv;
    swap   = accept && in_sof && pend_q;
    // The sof beat that triggers the swap must already see the new matrix.
    coef_use = swap ? shadow_q : active_q;
    px.r = in_r;
    px.g = in_g;
    px.b = in_b;

    vld_d = vld_q;
    sof_d = sof_q;
    if (adv) begin
      vld_d = {vld_q[1:0], in_valid};
      sof_d = {sof_q[1:0], in_valid && in_sof};
    end

    shadow_d = shadow_q;
    if (cfg_we && cfg_addr <= CFG_ADDR_MAX) shadow_d[cfg_addr] = cfg_data;
    active_d = swap ? shadow_q : active_q;
    pend_d   = pend_q;
    if (cfg_commit)  pend_d = 1'b1;
    else if (swap)   pend_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q    <= '0;
      sof_q    <= '0;
      shadow_q <= IDENTITY_MAT;
      active_q <= IDENTITY_MAT;
      pend_q   <= 1'b0;
    end else begin
      vld_q    <= vld_d;
      sof_q    <= sof_d;
      shadow_q <= shadow_d;
      active_q <= active_d;
      pend_q   <= pend_d;
    end
  end

  for (genvar i = 0; i < ROW_LEN; i++) begin : g_row
    ccm_row u_row (
      .clk      (clk),
      .rst_n    (rst_n),
      .adv      (adv),
      .px_dat   (px),
      .coef_dat (coef_use[i*ROW_LEN +: ROW_LEN]),
      .out_dat  (row_out[i])
`ifdef CCM_SAT_COUNT_EN
      , .out_clamp(row_clamp[i])
`endif
    );
`ifndef CCM_SAT_COUNT_EN
    assign row_clamp[i] = 1'b0;
`endif
  end

`ifdef CCM_SAT_COUNT_EN
  logic [15:0] sat_cnt_d, sat_cnt_q;

  always_comb begin
    sat_cnt_d = sat_cnt_q;
    if (swap)
      sat_cnt_d = '0;
    else if (vld_q[2] && out_ready && |row_clamp && sat_cnt_q != 16'hFFFF)
      sat_cnt_d = sat_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sat_cnt_q <= '0;
    else        sat_cnt_q <= sat_cnt_d;
  end

  assign sat_count = sat_cnt_q;
`else
  logic unused_row_clamp;
  assign unused_row_clamp = |row_clamp;
`endif

  assign in_ready    = adv;
  assign out_valid   = vld_q[2];
  assign out_sof     = sof_q[2];
  assign out_r       = row_out[0];
  assign out_g       = row_out[1];
  assign out_b       = row_out[2];
  assign cfg_pending = pend_q;
endmodule

// File: tb/tb_color_correction_matrix.sv
// Scoreboard bench for color_correction_matrix: reference matrix model predicts each accepted beat,
// a negedge monitor pops and compares every output handshake.
module tb_color_correction_matrix;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, in_sof;
  logic [7:0]  in_r, in_g, in_b;
  logic        out_valid, out_ready, out_sof;
  logic [31:0] out_r, out_g, out_b;
  logic        cfg_we, cfg_commit, cfg_pending;
  logic [3:0]  cfg_addr;
  logic [15:0] cfg_data;
`ifdef CCM_SAT_COUNT_EN
  logic [15:0] sat_count;
`endif

  color_correction_matrix dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_sof(in_sof),
    .in_r(in_r), .in_g(in_g), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_sof(out_sof),
    .out_r(out_r), .out_g(out_g), .out_b(out_b),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .cfg_commit(cfg_commit), .cfg_pending(cfg_pending)
`ifdef CCM_SAT_COUNT_EN
    , .sat_count(sat_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    bit sof;
    int r;
    int g;
    int b;
    bit clamp;
  } exp_t;

  exp_t sb[$];
  int   m_act[9];
  int   m_sh[9];
  bit   m_pend;
  int   exp_sat;
  int   checks = 0;
  int   failures = 0;
  int   popped = 0;
  int   last_r, last_g, last_b;
  int   rdy_mode = 0;
  bit   stall_q = 0;
  logic [31:0] held_r, held_g, held_b;
  logic        held_sof;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string nm);
    checks++;
    failures++;
    $display("FAIL %s: wait bound expired at %0t", nm, $time);
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 9; i++) begin
      m_act[i] = (i % 4 == 0) ? 256 : 0;
      m_sh[i]  = m_act[i];
    end
    m_pend  = 0;
    exp_sat = 0;
  endfunction

  function automatic int clampv(input int s);
    if (s < 0) return 0;
    if (s > 65535) return 65535;
    return s;
  endfunction

  function automatic exp_t predict(input bit sof, input int r, input int g, input int b);
    exp_t e;
    int   s[3];
    e.sof   = sof;
    e.clamp = 0;
    for (int k = 0; k < 3; k++) begin
      s[k] = r * m_act[3*k] + g * m_act[3*k+1] + b * m_act[3*k+2];
      if (s[k] < 0 || s[k] > 65535) e.clamp = 1;
    end
    e.r = clampv(s[0]);
    e.g = clampv(s[1]);
    e.b = clampv(s[2]);
    return e;
  endfunction

  // Everything is sampled at negedge, where it is stable for the coming rising edge.
  always @(negedge clk) begin
    exp_t e;
    bit   hs, acc, swap, e_clamp;
    if (!rst_n) begin
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_sof", out_sof, 0);
      chk("rst_pending", cfg_pending, 0);
      chk("rst_out_r", out_r, 0);
      sb.delete();
      model_reset();
      stall_q = 0;
    end else begin
      chk("pending", cfg_pending, m_pend);
      chk("in_ready", in_ready, !out_valid || out_ready);
      chk("sof_without_valid", out_sof && !out_valid, 0);
`ifdef CCM_SAT_COUNT_EN
      chk("sat_count", sat_count, exp_sat);
`endif
      if (stall_q) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_r", out_r, held_r);
        chk("stall_g", out_g, held_g);
        chk("stall_b", out_b, held_b);
        chk("stall_sof", out_sof, held_sof);
      end
      stall_q  = out_valid && !out_ready;
      held_r   = out_r;
      held_g   = out_g;
      held_b   = out_b;
      held_sof = out_sof;

      hs      = out_valid && out_ready;
      e_clamp = 0;
      if (hs) begin
        if (sb.size() == 0) begin
          timeout_fail("unexpected_output_beat");
        end else begin
          e = sb.pop_front();
          chk("out_r", out_r, e.r);
          chk("out_g", out_g, e.g);
          chk("out_b", out_b, e.b);
          chk("out_sof", out_sof, e.sof);
          e_clamp = e.clamp;
        end
        popped++;
        last_r = out_r;
        last_g = out_g;
        last_b = out_b;
      end

      acc  = in_valid && in_ready;
      swap = acc && in_sof && m_pend;
      if (swap) m_act = m_sh;
      if (acc) sb.push_back(predict(in_sof, int'(in_r), int'(in_g), int'(in_b)));
      if (swap) exp_sat = 0;
      else if (hs && e_clamp && exp_sat < 65535) exp_sat++;
      if (cfg_we && cfg_addr <= 4'd8) m_sh[cfg_addr] = int'($signed(cfg_data));
      if (cfg_commit) m_pend = 1;
      else if (swap)  m_pend = 0;
    end
  end

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = ($urandom_range(0, 3) != 0);
      default: out_ready = 1'b0;
    endcase
  end

  task automatic send(input bit sof, input int r, input int g, input int b);
    int   n;
    logic rdy;
    in_valid = 1'b1;
    in_sof   = sof;
    in_r     = 8'(r);
    in_g     = 8'(g);
    in_b     = 8'(b);
    n = 0;
    do begin
      @(negedge clk);
      rdy = in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!rdy && n < 200);
    if (!rdy) timeout_fail("send_accept");
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_sof   = 1'b0;
  endtask

  task automatic drain();
    int n;
    idle();
    n = 0;
    while ((sb.size() != 0 || out_valid) && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 300) timeout_fail("drain");
  endtask

  task automatic cfg_wr(input int a, input int d);
    cfg_we   = 1'b1;
    cfg_addr = 4'(a);
    cfg_data = 16'(d);
    @(posedge clk);
    #1;
    cfg_we = 1'b0;
  endtask

  task automatic commit();
    cfg_commit = 1'b1;
    @(posedge clk);
    #1;
    cfg_commit = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, p0, v;
    rst_n = 1'b0;
    in_valid = 0; in_sof = 0; in_r = 0; in_g = 0; in_b = 0;
    out_ready = 1'b1;
    cfg_we = 0; cfg_addr = 0; cfg_data = 0; cfg_commit = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Identity after reset, latency and sof travel
    send(1, 10, 2, 255);
    idle();
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("latency", lat, 3);
    chk("ident_sof", out_sof, 1);
    chk("ident_r", out_r, 2560);
    chk("ident_g", out_g, 512);
    chk("ident_b", out_b, 65280);
    drain();

    // Negative clamp
    cfg_wr(0, -256);
    commit();
    chk("pending_set", cfg_pending, 1);
    send(1, 100, 0, 0);
    drain();
    chk("neg_clamp_r", last_r, 0);
`ifdef CCM_SAT_COUNT_EN
    chk("neg_clamp_sat", sat_count, 1);
`endif

    // Positive clamp and in-range scaling
    cfg_wr(0, 512);
    commit();
    send(1, 200, 0, 0);
    drain();
    chk("pos_clamp_r", last_r, 65535);
    send(0, 100, 0, 0);
    drain();
    chk("pos_range_r", last_r, 51200);
`ifdef CCM_SAT_COUNT_EN
    chk("pos_clamp_sat", sat_count, 1);
`endif

    // Back to identity, then commit timing
    cfg_wr(0, 256);
    commit();
    send(1, 0, 0, 0);
    drain();
    cfg_wr(0, 128);
    commit();
    send(0, 100, 0, 0);
    chk("pending_hold", cfg_pending, 1);
    drain();
    chk("commit_old_r", last_r, 25600);
    send(1, 100, 0, 0);
    chk("pending_clear", cfg_pending, 0);
    drain();
    chk("commit_new_r", last_r, 12800);

    // Backpressure mid-stream
    p0 = popped;
    fork
      begin
        for (int i = 0; i < 8; i++)
          send(0, $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255));
        idle();
      end
      begin
        repeat (3) @(posedge clk);
        #1 rdy_mode = 2;
        repeat (5) @(negedge clk);
        chk("bp_in_ready", in_ready, 0);
        chk("bp_out_valid", out_valid, 1);
        @(posedge clk);
        #1 rdy_mode = 0;
      end
    join
    drain();
    chk("bp_beat_count", popped - p0, 8);

    // Random traffic, config writes, commits and stalls
    rdy_mode = 1;
    for (int c = 0; c < 600; c++) begin
      in_valid   = ($urandom_range(0, 3) != 0);
      in_sof     = ($urandom_range(0, 7) == 0);
      in_r       = 8'($urandom_range(0, 255));
      in_g       = 8'($urandom_range(0, 255));
      in_b       = 8'($urandom_range(0, 255));
      cfg_we     = ($urandom_range(0, 3) == 0);
      cfg_addr   = 4'($urandom_range(0, 15));
      v          = $urandom_range(0, 1279);
      cfg_data   = 16'(v - 512);
      cfg_commit = ($urandom_range(0, 11) == 0);
      @(posedge clk);
      #1;
    end
    cfg_we = 0;
    cfg_commit = 0;
    rdy_mode = 0;
    drain();

    // Async reset with beats in flight and a commit armed
    cfg_wr(4, 0);
    commit();
    send(1, 1, 1, 1);
    cfg_commit = 1'b1;
    send(0, 2, 2, 2);
    cfg_commit = 1'b0;
    send(0, 3, 3, 3);
    idle();
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", out_valid, 0);
    chk("async_rst_pending", cfg_pending, 0);
    chk("async_rst_in_ready", in_ready, 1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    send(1, 10, 2, 255);
    drain();
    chk("post_rst_r", last_r, 2560);
    chk("post_rst_g", last_g, 512);
    chk("post_rst_b", last_b, 65280);
    chk("scoreboard_empty", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
